dm_responder: RTL and testbench
===============================

# dm_responder

Multi-cycle data-memory responder serving the pipeline CPU's MEM stage. It accepts the stage's Mem_r/Mem_w requests and holds the pipeline with a stall signal for a fixed access latency. It then performs the word access and returns read data with a one-cycle completion pulse. It replaces the single-cycle data memory when the team models realistic memory latency.

## Interface

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored; power of two, ≥ 4.
- LATENCY, 2: BUSY cycles per access; integer, ≥ 1.
- ADDR_W, log2(DEPTH_WORDS): word-index width (derived).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- Mem_r  input  1  read request from the MEM stage.
- Mem_w  input  1  write request from the MEM stage.
- Mem_addr  input  32  byte address.
- Mem_w_data  input  32  write data.
- Mem_r_data  output  32  registered read data.
- Mem_stall  output  1  freezes the pipeline; combinational from state and request.
- Mem_done  output  1  one-cycle completion pulse, registered.
- Mem_err  output  1  one-cycle error pulse, coincident with Mem_done.

## Operation

- States: IDLE, BUSY, RESP; 2-bit state register plus a latency counter of width ceil(log2(LATENCY))+1.
- IDLE:
  - With Mem_r or Mem_w high, Mem_stall = 1 in the same cycle.
  - At the edge, op, word index and write data are captured, the counter loads LATENCY-1, and the state goes to BUSY.
- BUSY:
  - Mem_stall = 1.
  - Counter decrements each edge.
  - At the edge where the counter is 0, the access is performed and the state goes to RESP:
    - Write: mem[idx] ← captured data.
    - Read: Mem_r_data ← mem[idx].
- RESP:
  - Mem_stall = 0, Mem_done = 1; the pipeline advances at this edge.
  - Request inputs are ignored in RESP, because they still belong to the completed access.
  - Next state is IDLE unconditionally.
- Word index = Mem_addr[ADDR_W+1:2]. Bits above ADDR_W+1 are ignored, so addresses alias modulo 4·DEPTH_WORDS.
- Misaligned address (Mem_addr[1:0] ≠ 0): low bits are ignored, the access proceeds at the truncated word, and Mem_err = 1 in RESP.
- Mem_r and Mem_w both high at capture: treated as a write, Mem_r_data unchanged, Mem_err = 1 in RESP.
- Mem_r_data holds the last completed read value. Writes never change it.
- Request inputs are sampled only in IDLE. Changes during BUSY have no effect; the pipeline holds them stable by contract.

## Timing

- Request first visible in IDLE at cycle T:
  - BUSY spans T+1 … T+LATENCY.
  - RESP at T+LATENCY+1, with Mem_done = 1 and Mem_r_data valid.
  - Mem_stall is high for cycles T … T+LATENCY, i.e. LATENCY+1 cycles.
- A back-to-back request can be captured in IDLE at T+LATENCY+2 at the earliest. Throughput is one access per LATENCY+2 cycles.
- Reset (rst_n = 0 at an edge) forces:
  - state = IDLE, counter = 0, Mem_r_data = 0, Mem_done = 0, Mem_err = 0.
  - Mem_stall = 0 while in reset.
- Memory contents are not cleared by reset.
- Reset mid-BUSY aborts the access. A write is not performed unless its completion edge has already passed.
- rst_n takes priority over every transition, including the completion edge.

## Test plan

- Reset: hold rst_n = 0 for 2 cycles, then release with no request → Mem_r_data = 0, Mem_done = 0, Mem_stall = 0, state IDLE.
- Write then read, LATENCY = 2:
  - Mem_w = 1, addr 0x10, data 0xDEADBEEF at T → Mem_stall high T…T+2, Mem_done at T+3.
  - Then read 0x10 → Mem_r_data = 0xDEADBEEF at its RESP cycle.
- Aliasing, DEPTH_WORDS = 256:
  - Write 0x12345678 to 0x404.
  - Read 0x004 → 0x12345678, Mem_err = 0.
- Misaligned and conflict:
  - Read 0x13 after writing 0xA5A5A5A5 to 0x10 → Mem_r_data = 0xA5A5A5A5, Mem_err = 1.
  - Mem_r = Mem_w = 1, data 0x1 at 0x20 → word 8 = 0x1, Mem_r_data unchanged, Mem_err = 1.
- Reset mid-access: write 0x55 to 0x30 (old value 0x0), assert rst_n = 0 in the first BUSY cycle → no Mem_done, and a later read of 0x30 returns 0x0.
- Back-to-back reads of 0x10 then 0x14 held continuously → second capture at T+4, Mem_done pulses exactly at T+3 and T+7.

Source files
------------

// File: rtl/dm_responder_if.sv
// Bundle of MEM-stage request/response signals shared between the pipeline
// and the multi-cycle data-memory responder.
interface dm_responder_if;
    logic        Mem_r;
    logic        Mem_w;
    logic [31:0] Mem_addr;
    logic [31:0] Mem_w_data;
    logic [31:0] Mem_r_data;
    logic        Mem_stall;
    logic        Mem_done;
    logic        Mem_err;

    // Pipeline side: issues requests, observes stall and completion.
    modport master (
        output Mem_r, Mem_w, Mem_addr, Mem_w_data,
        input  Mem_r_data, Mem_stall, Mem_done, Mem_err
    );

    // Responder side: serves requests, drives stall and completion.
    modport slave (
        input  Mem_r, Mem_w, Mem_addr, Mem_w_data,
        output Mem_r_data, Mem_stall, Mem_done, Mem_err
    );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the pipeline MEM stage.
// A request seen in IDLE is captured, the pipeline is stalled for LATENCY
// BUSY cycles, the word access is performed on the last BUSY edge, and a
// single RESP cycle reports completion (with an error flag for misaligned
// addresses or simultaneous read/write requests).
module dm_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dm_responder_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   idx_q,      idx_d;
    logic [31:0]         wdata_q,    wdata_d;
    logic                flag_err_q, flag_err_d;
    logic [31:0]         r_data_q,   r_data_d;
    logic                done_q,     done_d;
    logic                err_q,      err_d;
    logic                mem_we;
    logic                stall;

    logic [31:0]         mem [DEPTH_WORDS];

    // Address bits above the word index only alias; they are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.Mem_addr[31:ADDR_W+2]};

    // Next-state, capture, access and stall decode for the access sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        flag_err_d = flag_err_q;
        r_data_d   = r_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        stall      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Mem_r || bus.Mem_w) begin
                    stall      = 1'b1;
                    is_write_d = bus.Mem_w;
                    idx_d      = bus.Mem_addr[ADDR_W+1:2];
                    wdata_d    = bus.Mem_w_data;
                    flag_err_d = (bus.Mem_addr[1:0] != 2'b00) ||
                                 (bus.Mem_r && bus.Mem_w);
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    if (is_write_q) begin
                        mem_we = 1'b1;
                    end else begin
                        r_data_d = mem[idx_q];
                    end
                    done_d  = 1'b1;
                    err_d   = flag_err_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    // State, captured request and registered response, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            flag_err_q <= 1'b0;
            r_data_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            flag_err_q <= flag_err_d;
            r_data_q   <= r_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Storage array keeps its contents across reset; reset still blocks a pending write.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.Mem_r_data = r_data_q;
    assign bus.Mem_stall  = stall;
    assign bus.Mem_done   = done_q;
    assign bus.Mem_err    = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: a driver issues requests and queues the
// expected completion, a monitor checks every Mem_done pulse against it.
module tb_dm_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_mis;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    dm_responder_if bus ();

    dm_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index used to time-stamp requests and completions.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_mis++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Issue one access at the current cycle T, hold it through BUSY and RESP,
    // and return at the start of cycle T+LAT+2 with the inputs still held.
    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [31:0] addr, input logic [31:0] data);
        int unsigned idx;
        exp_t        e;
        idx = (addr / 4) % DEPTH;
        if (w) model_mem[idx] = data;
        else   model_rdata    = model_mem[idx];
        e.rdata = model_rdata;
        e.err   = (addr % 4 != 0) || (r && w);
        e.cyc   = cyc + LAT + 1;
        sb_q.push_back(e);
        bus.Mem_r      = r;
        bus.Mem_w      = w;
        bus.Mem_addr   = addr;
        bus.Mem_w_data = data;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            checkOutput("stall_busy", {31'b0, bus.Mem_stall}, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("stall_resp", {31'b0, bus.Mem_stall}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        bus.Mem_r = 1'b0;
        bus.Mem_w = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checkOutput("stall_idle", {31'b0, bus.Mem_stall}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // Start a write and pull reset during its first BUSY cycle; no completion may follow.
    task automatic abortedWrite(input logic [31:0] addr, input logic [31:0] data);
        bus.Mem_r      = 1'b0;
        bus.Mem_w      = 1'b1;
        bus.Mem_addr   = addr;
        bus.Mem_w_data = data;
        @(negedge clk);
        checkOutput("stall_capture", {31'b0, bus.Mem_stall}, 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        bus.Mem_w = 1'b0;
        @(negedge clk);
        checkOutput("stall_in_reset", {31'b0, bus.Mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        model_rdata = 32'h0;
        @(negedge clk);
        checkOutput("rdata_after_abort", bus.Mem_r_data, 32'h0);
        checkOutput("done_after_abort", {31'b0, bus.Mem_done}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completion pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.Mem_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", {31'b0, bus.Mem_done}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("done_cycle", cyc, mon_e.cyc);
                    checkOutput("r_data", bus.Mem_r_data, mon_e.rdata);
                    checkOutput("err", {31'b0, bus.Mem_err}, {31'b0, mon_e.err});
                end
            end else if (bus.Mem_err !== 1'b0 || bus.Mem_done !== 1'b0) begin
                checkOutput("err_or_done_idle", {30'b0, bus.Mem_done, bus.Mem_err}, 32'd0);
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic        r, w;
        logic [31:0] addr;
        n_vec          = 0;
        n_mis          = 0;
        model_rdata    = 32'h0;
        rst_n          = 1'b0;
        bus.Mem_r      = 1'b0;
        bus.Mem_w      = 1'b0;
        bus.Mem_addr   = 32'h0;
        bus.Mem_w_data = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_rdata", bus.Mem_r_data, 32'h0);
        checkOutput("reset_done", {31'b0, bus.Mem_done}, 32'd0);
        checkOutput("reset_stall", {31'b0, bus.Mem_stall}, 32'd0);
        checkOutput("reset_err", {31'b0, bus.Mem_err}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, i * 4, 32'h0);
        idleCycles(1);

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
        idleCycles(1);

        applyStimulus(1'b0, 1'b1, 32'h404, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h004, 32'h0);
        idleCycles(2);

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b0, 32'h13, 32'h0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
        idleCycles(1);

        abortedWrite(32'h30, 32'h55);
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0);
        idleCycles(1);

        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h14, 32'h0);
        idleCycles(2);

        for (int t = 0; t < 300; t++) begin
            r    = 1'($urandom_range(0, 1));
            w    = ($urandom_range(0, 3) == 0) ? 1'b1 : ~r;
            addr = 32'($urandom_range(0, 7) * 1024 + $urandom_range(0, 15) * 4);
            if ($urandom_range(0, 4) == 0) addr = addr + 32'($urandom_range(1, 3));
            applyStimulus(r, w, addr, $urandom);
            if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
        end
        idleCycles(4);

        checkOutput("pending_responses", sb_q.size(), 32'd0);
        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
